// File: rtl/multicast_tree_dist_seq.sv
// -----------------------------------------------------------------------------
// multicast_tree_dist_seq
//
// Registered binary distribution tree. One input word fans out to any subset
// of NUM_OUTPUT_DATA ports. There is one register per tree level plus an
// output register, so latency is NUM_LEVEL+1. Subtrees that no destination
// bit reaches are pruned and hold valid=0 and data=0. A word stays in the
// output stage until every selected port has taken it. Ports that are
// already served drop valid while the others retry. The pipeline advances
// only when the output stage has fully drained.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   i_valid      input word valid
//   i_data_bus   input word
//   i_dest_mask  destination ports, bit k selects port k
//   o_ready      input accepted when i_valid && o_ready (combinational)
//   o_valid      per-port valid
//   o_data_bus   port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_out_ready  per-port sink ready
//   i_en         pipeline advance enable, low holds all state
//   i_flush      synchronous clear of all in-flight words
//   o_busy       any stage holds a word
// -----------------------------------------------------------------------------
module multicast_tree_dist_seq #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [DATA_WIDTH-1:0]                 i_data_bus,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_dest_mask,
    output logic                                  o_ready,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_out_ready,
    input  logic                                  i_en,
    input  logic                                  i_flush,
    output logic                                  o_busy
);

    localparam int NUM_LEVEL = $clog2(NUM_OUTPUT_DATA);
    localparam int N         = NUM_OUTPUT_DATA;
    localparam int NODES     = N - 1;

    // Tree nodes use heap numbering. Node 1 is stage 0. Stage L holds nodes
    // 2^L .. 2^(L+1)-1, and the children of node i are 2i and 2i+1. Each
    // node keeps its submask at the global bit positions it owns, and all
    // other bits stay zero. This lets a child take its half with a single
    // AND against a constant region mask.
    logic                  vld_q  [1:NODES];
    logic                  vld_d  [1:NODES];
    logic [N-1:0]          mask_q [1:NODES];
    logic [N-1:0]          mask_d [1:NODES];
    logic [DATA_WIDTH-1:0] data_q [1:NODES];
    logic [DATA_WIDTH-1:0] data_d [1:NODES];

    logic [DATA_WIDTH-1:0] slot_data_q [N];
    logic [DATA_WIDTH-1:0] slot_data_d [N];
    logic [N-1:0]          rem_q;
    logic [N-1:0]          rem_d;

    logic                  adv;
    logic [N-1:0]          sub;
    logic                  hit;
    logic                  in_live;
    logic                  busy;

    // Mask bits owned by heap node idx.
    function automatic logic [N-1:0] node_region(input int idx);
        logic [N-1:0] r;
        int           lvl;
        int           w;
        int           j;
        lvl = 0;
        for (int l = 1; l < NUM_LEVEL; l++) begin
            if (idx >= (1 << l)) begin
                lvl = l;
            end
        end
        w = N >> lvl;
        j = idx - (1 << lvl);
        for (int b = 0; b < N; b++) begin
            r[b] = (b >= j * w) && (b < (j + 1) * w);
        end
        return r;
    endfunction

    // Global stall: the tree moves only once no selected port is still
    // waiting. This puts i_out_ready on a combinational path to o_ready.
    always_comb begin
        adv     = i_en && !i_flush && ((rem_q & ~i_out_ready) == '0);
        o_ready = adv && rst;
    end

    always_comb begin
        for (int i = 1; i <= NODES; i++) begin
            vld_d[i]  = vld_q[i];
            mask_d[i] = mask_q[i];
            data_d[i] = data_q[i];
        end
        for (int k = 0; k < N; k++) begin
            slot_data_d[k] = slot_data_q[k];
        end
        rem_d   = rem_q;
        sub     = '0;
        hit     = 1'b0;
        in_live = 1'b0;

        if (i_flush) begin
            for (int i = 1; i <= NODES; i++) begin
                vld_d[i]  = 1'b0;
                mask_d[i] = '0;
                data_d[i] = '0;
            end
            for (int k = 0; k < N; k++) begin
                slot_data_d[k] = '0;
            end
            rem_d = '0;
        end else if (adv) begin
            // A word with an empty mask is accepted here and then dropped.
            in_live   = i_valid && (i_dest_mask != '0);
            vld_d[1]  = in_live;
            mask_d[1] = in_live ? i_dest_mask : '0;
            data_d[1] = in_live ? i_data_bus : '0;
            for (int i = 2; i <= NODES; i++) begin
                sub       = mask_q[i/2] & node_region(i);
                hit       = vld_q[i/2] && (sub != '0);
                vld_d[i]  = hit;
                mask_d[i] = hit ? sub : '0;
                data_d[i] = hit ? data_q[i/2] : '0;
            end
            // Output slot k is leaf k of a virtual last level, fed by node (N+k)/2.
            for (int k = 0; k < N; k++) begin
                hit            = vld_q[(N+k)/2] && mask_q[(N+k)/2][k];
                rem_d[k]       = hit;
                slot_data_d[k] = hit ? data_q[(N+k)/2] : '0;
            end
        end else if (i_en) begin
            rem_d = rem_q & ~i_out_ready;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= NODES; i++) begin
                vld_q[i]  <= 1'b0;
                mask_q[i] <= '0;
                data_q[i] <= '0;
            end
            for (int k = 0; k < N; k++) begin
                slot_data_q[k] <= '0;
            end
            rem_q <= '0;
        end else begin
            for (int i = 1; i <= NODES; i++) begin
                vld_q[i]  <= vld_d[i];
                mask_q[i] <= mask_d[i];
                data_q[i] <= data_d[i];
            end
            for (int k = 0; k < N; k++) begin
                slot_data_q[k] <= slot_data_d[k];
            end
            rem_q <= rem_d;
        end
    end

    always_comb begin
        busy = (rem_q != '0);
        for (int i = 1; i <= NODES; i++) begin
            busy = busy || vld_q[i];
        end
        o_busy = busy;
    end

    assign o_valid = rem_q;

    // A slot that has already been served reads 0 while its siblings retry.
    for (genvar k = 0; k < N; k++) begin : g_out
        assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] = rem_q[k] ? slot_data_q[k] : '0;
    end

endmodule

// File: tb/tb_multicast_tree_dist_seq.sv
module tb_multicast_tree_dist_seq;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int NL = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            i_valid = 1'b0;
    logic [DW-1:0]   i_data_bus = '0;
    logic [N-1:0]    i_dest_mask = '0;
    logic            o_ready;
    logic [N-1:0]    o_valid;
    logic [N*DW-1:0] o_data_bus;
    logic [N-1:0]    i_out_ready = '0;
    logic            i_en = 1'b0;
    logic            i_flush = 1'b0;
    logic            o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicast_tree_dist_seq #(.DATA_WIDTH(DW), .NUM_OUTPUT_DATA(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_data_bus  (i_data_bus),
        .i_dest_mask (i_dest_mask),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_data_bus  (o_data_bus),
        .i_out_ready (i_out_ready),
        .i_en        (i_en),
        .i_flush     (i_flush),
        .o_busy      (o_busy)
    );

    // Reference model: a plain delay line of NL words. Each word keeps its
    // full destination mask, followed by the output slots. The tree
    // structure is invisible at the ports.
    logic          m_vld  [NL];
    logic [DW-1:0] m_data [NL];
    logic [N-1:0]  m_mask [NL];
    logic [N-1:0]  m_rem;
    logic [DW-1:0] m_out;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NL; i++) begin
                m_vld[i]  <= 1'b0;
                m_data[i] <= '0;
                m_mask[i] <= '0;
            end
            m_rem <= '0;
            m_out <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < NL; i++) begin
                m_vld[i] <= 1'b0;
            end
            m_rem <= '0;
        end else if (i_en && ((m_rem & ~i_out_ready) == '0)) begin
            m_out <= m_data[NL-1];
            m_rem <= m_vld[NL-1] ? m_mask[NL-1] : '0;
            for (int i = NL-1; i > 0; i--) begin
                m_vld[i]  <= m_vld[i-1];
                m_data[i] <= m_data[i-1];
                m_mask[i] <= m_mask[i-1];
            end
            m_vld[0]  <= i_valid && (i_dest_mask != '0);
            m_data[0] <= i_data_bus;
            m_mask[0] <= i_dest_mask;
        end else if (i_en) begin
            m_rem <= m_rem & ~i_out_ready;
        end
    end

    task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] spread(input logic [N-1:0] v, input logic [DW-1:0] w);
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) begin
            r[k*DW +: DW] = v[k] ? w : '0;
        end
        return r;
    endfunction

    task automatic check_model(input string tag);
        logic e_busy;
        logic e_ready;
        e_busy = (m_rem != '0);
        for (int i = 0; i < NL; i++) begin
            e_busy = e_busy || m_vld[i];
        end
        e_ready = rst && i_en && !i_flush && ((m_rem & ~i_out_ready) == '0);
        chk({tag, ".ready"}, N*DW'(o_ready), N*DW'(e_ready));
        chk({tag, ".valid"}, N*DW'(o_valid), N*DW'(m_rem));
        chk({tag, ".data"},  o_data_bus,     spread(m_rem, m_out));
        chk({tag, ".busy"},  N*DW'(o_busy),  N*DW'(e_busy));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [N-1:0] m,
                         input logic [N-1:0] rdy, input logic en, input logic fl);
        i_valid     = v;
        i_data_bus  = d;
        i_dest_mask = m;
        i_out_ready = rdy;
        i_en        = en;
        i_flush     = fl;
    endtask

    task automatic cyc(input string tag, input logic v, input logic [DW-1:0] d, input logic [N-1:0] m,
                       input logic [N-1:0] rdy, input logic en, input logic fl);
        drive(v, d, m, rdy, en, fl);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [N-1:0]  m;
        logic [N-1:0]  rdy;
        logic          e_ready;
        logic [N-1:0]  e_valid;
        logic          e_busy;
        logic [DW-1:0] e_word;
    } vec_t;

    localparam int NROWS = 26;
    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic [N-1:0] m,
                                input logic [N-1:0] rdy, input logic er, input logic [N-1:0] ev,
                                input logic eb, input logic [DW-1:0] ew);
        vec_t t;
        t.v = v; t.d = d; t.m = m; t.rdy = rdy;
        t.e_ready = er; t.e_valid = ev; t.e_busy = eb; t.e_word = ew;
        return t;
    endfunction

    initial begin
        // broadcast
        tbl[0]  = mk(1, 32'hDEADBEEF, 8'hFF, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[1]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[2]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[3]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[4]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'hFF, 1, 32'hDEADBEEF);
        tbl[5]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        // multicast with pruning
        tbl[6]  = mk(1, 32'h11, 8'h05, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[7]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[8]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[9]  = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[10] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h05, 1, 32'h11);
        tbl[11] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        // partial delivery, second word delayed by the stall
        tbl[12] = mk(1, 32'hA5, 8'h0F, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[13] = mk(1, 32'hB6, 8'h30, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[14] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[15] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 1, 32'h0);
        tbl[16] = mk(0, 32'h0, 8'h00, 8'h03, 0, 8'h0F, 1, 32'hA5);
        tbl[17] = mk(0, 32'h0, 8'h00, 8'h03, 0, 8'h0C, 1, 32'hA5);
        tbl[18] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h0C, 1, 32'hA5);
        tbl[19] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h30, 1, 32'hB6);
        tbl[20] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        // zero mask: accepted, never delivered
        tbl[21] = mk(1, 32'h77, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[22] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[23] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[24] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);
        tbl[25] = mk(0, 32'h0, 8'h00, 8'hFF, 1, 8'h00, 0, 32'h0);

        // reset state, with inputs that would otherwise be accepted
        drive(1, 32'h12345678, 8'hFF, 8'hFF, 1, 0);
        #3;
        chk("rst.ready", N*DW'(o_ready), '0);
        chk("rst.valid", N*DW'(o_valid), '0);
        chk("rst.data",  o_data_bus,     '0);
        chk("rst.busy",  N*DW'(o_busy),  '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int r = 0; r < NROWS; r++) begin
            drive(tbl[r].v, tbl[r].d, tbl[r].m, tbl[r].rdy, 1, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d.ready", r), N*DW'(o_ready), N*DW'(tbl[r].e_ready));
            chk($sformatf("tbl%0d.valid", r), N*DW'(o_valid), N*DW'(tbl[r].e_valid));
            chk($sformatf("tbl%0d.busy", r),  N*DW'(o_busy),  N*DW'(tbl[r].e_busy));
            chk($sformatf("tbl%0d.data", r),  o_data_bus,     spread(tbl[r].e_valid, tbl[r].e_word));
            @(posedge clk);
            #1;
        end

        // streaming: back-to-back words, data = index, random masks
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("strm%0d", i), 1, DW'(i), (i % 5 == 3) ? 8'h00 : N'($urandom), 8'hFF, 1, 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc("drain", 0, '0, '0, 8'hFF, 1, 0);
        end

        // hold then flush mid-stream
        for (int i = 0; i < 5; i++) begin
            cyc("pre_hold", 1, 32'h100 + DW'(i), N'($urandom) | 8'h01, 8'hFF, 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hBAD0, 8'hFF, 8'hFF, 0, 0);
            @(negedge clk);
            chk("hold.ready", N*DW'(o_ready), '0);
            check_model("hold");
            @(posedge clk);
            #1;
        end
        drive(1, 32'hBAD1, 8'hFF, 8'hFF, 1, 1);
        @(negedge clk);
        chk("flush.ready", N*DW'(o_ready), '0);
        check_model("flush");
        @(posedge clk);
        #1;
        drive(0, '0, '0, 8'hFF, 1, 0);
        @(negedge clk);
        chk("post_flush.valid", N*DW'(o_valid), '0);
        chk("post_flush.busy",  N*DW'(o_busy),  '0);
        check_model("post_flush");
        @(posedge clk);
        #1;

        // randomized traffic with backpressure, holds and flushes
        for (int i = 0; i < 300; i++) begin
            cyc("rand", 1'($urandom_range(0, 1)), $urandom, N'($urandom),
                ($urandom_range(0, 1) == 1) ? 8'hFF : N'($urandom),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0));
        end

        // async reset with words in flight
        for (int i = 0; i < 3; i++) begin
            cyc("pre_rst", 1, 32'h200 + DW'(i), 8'hFF, 8'hFF, 1, 0);
        end
        drive(0, '0, '0, 8'hFF, 1, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.valid", N*DW'(o_valid), '0);
        chk("arst.data",  o_data_bus,     '0);
        chk("arst.busy",  N*DW'(o_busy),  '0);
        chk("arst.ready", N*DW'(o_ready), '0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_model("post_rst");
        @(posedge clk);
        #1;
        cyc("fresh", 1, 32'hCAFE0001, 8'h81, 8'hFF, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("fresh_wait", 0, '0, '0, 8'hFF, 1, 0);
        end
        drive(0, '0, '0, 8'hFF, 1, 0);
        @(negedge clk);
        chk("fresh.valid", N*DW'(o_valid), N*DW'(8'h81));
        chk("fresh.data",  o_data_bus,     spread(8'h81, 32'hCAFE0001));
        check_model("fresh_out");
        @(posedge clk);
        #1;
        cyc("fresh_done", 0, '0, '0, 8'hFF, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicast_tree_dist_seq.md
Name: multicast_tree_dist_seq

Overview:
- Parametrised successor to the fixed 1-to-8 registered wire binary tree. Distributes one input word to any subset of NUM_OUTPUT_DATA ports through a registered binary tree, one register per tree level plus an output register.
- Adds a per-word destination mask with subtree pruning, per-output ready backpressure, partial-delivery retry, and stall (not zeroing) on i_en low.
- Sits between the crossbar input stage and output ports, as a multicast distribution network.

Parameters:
- DATA_WIDTH, 32, bits per word; any value >= 1.
- NUM_OUTPUT_DATA, 8, output port count; power of 2, >= 2.
- NUM_LEVEL, $clog2(NUM_OUTPUT_DATA), localparam; tree depth. Latency is NUM_LEVEL+1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- i_valid  in  1  input word valid.
- i_data_bus  in  DATA_WIDTH  input word.
- i_dest_mask  in  NUM_OUTPUT_DATA  destination ports; bit k selects port k.
- o_ready  out  1  input accepted this cycle when i_valid && o_ready.
- o_valid  out  NUM_OUTPUT_DATA  per-port valid.
- o_data_bus  out  NUM_OUTPUT_DATA*DATA_WIDTH  port k at [k*DATA_WIDTH +: DATA_WIDTH].
- i_out_ready  in  NUM_OUTPUT_DATA  per-port sink ready.
- i_en  in  1  pipeline advance enable; low means hold all state.
- i_flush  in  1  synchronous clear of all in-flight words.
- o_busy  out  1  high when any stage holds a word.

Behaviour:
- Reset (rst=0, async): all stage valids, masks and data clear to 0. o_valid=0, o_data_bus=0, o_busy=0. o_ready=0 while rst=0.
- Tree stages:
  - Stage 0 holds 1 node; stage L holds 2^L nodes, for L = 0..NUM_LEVEL-1. The output stage holds NUM_OUTPUT_DATA slots.
  - Each node holds {valid, data, submask}. Node j of stage L owns mask bits [j*W +: W], where W = NUM_OUTPUT_DATA >> L.
  - On advance, child 2j receives the lower half of the parent's submask and child 2j+1 the upper half, both with the parent's data.
  - A child's valid = parent valid AND (child submask != 0). Pruned subtrees hold valid=0 and data=0.
- Output stage: slot k valid = rem[k]. o_data_bus slot k carries the word when rem[k]=1, else 0.
- Serve: served = rem & i_out_ready. A port transfer occurs when o_valid[k] && i_out_ready[k].
- Advance condition: adv = i_en && !i_flush && ((rem & ~i_out_ready) == 0).
  - adv=1: the whole pipeline shifts one stage (global stall scheme). Stage 0 loads the input if i_valid && o_ready, else loads a bubble.
  - adv=0 with i_en=1: stages hold; rem <= rem & ~i_out_ready, so served ports drop valid and only unserved ports retry.
  - i_en=0: full hold; rem is not updated and the outputs stay stable.
- o_ready = adv, combinational from i_out_ready. This is a documented timing path.
- Latency: with adv=1 every cycle, a word accepted at edge t appears on o_valid after edge t+NUM_LEVEL+1 (4 cycles for N=8). Back-to-back words sustain 1 word/cycle.
- Mask edge cases:
  - i_dest_mask=0 with i_valid=1: the word is accepted (o_ready honoured) and dropped at stage 0; no output ever asserts.
  - Mask all-ones: pure broadcast.
- i_flush=1: at the next edge all valids and rem clear; data goes to 0. Input is not accepted that cycle (o_ready=0). Flush has priority over advance.
- Simultaneous cases:
  - Output completing while a new word is accepted: both happen at the same edge.
  - i_en=0 with i_flush=1: flush wins.
- Reset mid-operation: all in-flight words are lost; outputs go to 0 immediately (asynchronous).
- o_busy = OR of all stage valids and rem bits.

Test Plan:
- Broadcast: N=8, DATA_WIDTH=32. Drive 0xDEADBEEF, mask 0xFF, all ready, i_en=1 at cycle 0 -> o_valid=0xFF with every slot 0xDEADBEEF at cycle 4, and o_valid=0 at cycle 5.
- Multicast and pruning: mask 0x05, data 0x11 -> o_valid=0x05 at cycle 4; slots 1-7 other than 2 read 0; internal right-subtree nodes stay invalid.
- Partial delivery: mask 0x0F, i_out_ready=0x03 for 2 cycles, then 0xFF -> o_valid=0x0F, then 0x0C held for 2 cycles, then 0; o_ready=0 during the stall; the next word's latency is extended by 2.
- Streaming: 16 back-to-back words, data = index, random masks, all ready -> 1 word/cycle, in-order per port, 4-cycle latency each; zero-mask words produce nothing.
- Hold and flush: i_en=0 for 3 cycles mid-stream -> outputs frozen and o_ready=0. Then i_flush=1 for 1 cycle -> o_valid=0 and o_busy=0 next cycle.
- Async reset: assert rst=0 between edges while words are in flight -> o_valid=0, o_data_bus=0 and o_busy=0 immediately; after release, a fresh word has 4-cycle latency.
